// File: rtl/pipeline_pkg.sv
// Shared defaults and types for the arithmetic-pipeline result collector.
package pipeline_pkg;

  localparam int unsigned DATA_W  = 3;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] res_t;

endpackage

// File: rtl/result_fifo.sv
// Small circular result buffer; a push into a full FIFO is accepted when a pop
// frees the head slot on the same edge.
module result_fifo #(
  parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
  parameter int unsigned DEPTH  = pipeline_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    accept_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              pop_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign accept_c = push & (~full | pop_ok);
  assign rdata    = mem_q[rptr_q];
  assign level    = level_q;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (accept_c) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok)   rptr_d = rptr_q + PTR_W'(1);
    case ({accept_c, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is cleared so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept_c) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pipeline_result_collector.sv
// Captures pipeline results LATENCY edges after each load, buffers them for a
// valid/ready consumer and keeps a running sum, count and sticky drop flag.
module pipeline_result_collector #(
  parameter int unsigned DATA_W  = pipeline_pkg::DATA_W,
  parameter int unsigned LATENCY = pipeline_pkg::LATENCY,
  parameter int unsigned DEPTH   = pipeline_pkg::DEPTH,
  parameter int unsigned SUM_W   = pipeline_pkg::SUM_W,
  parameter int unsigned CNT_W   = pipeline_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       res_in,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic [SUM_W-1:0]        sum,
  output logic [CNT_W-1:0]        count,
  output logic                    drop_err
);

  logic [LATENCY-1:0] vtag_q, vtag_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drop_q, drop_d;
  logic               cap, pop, accept, empty;

  assign cap       = vtag_q[LATENCY-1];
  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clear_n  (clear_n),
    .push     (cap),
    .pop      (pop),
    .wdata    (res_in),
    .rdata    (out_data),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .accept_c (accept)
  );

  // Tag line mirrors the pipeline depth; res_in is only looked at when accepted.
  always_comb begin
    vtag_d    = '0;
    vtag_d[0] = load;
    for (int unsigned i = 1; i < LATENCY; i++) vtag_d[i] = vtag_q[i-1];
    sum_d   = sum_q;
    count_d = count_q;
    drop_d  = drop_q | (cap & full & ~pop);
    if (accept) begin
      sum_d   = sum_q + SUM_W'(res_in);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      vtag_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      vtag_q  <= vtag_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign sum      = sum_q;
  assign count    = count_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Table-driven bench with a FIFO scoreboard; a second instance with a 4-bit
// accumulator shares the stimulus to exercise sum wraparound.
module tb_pipeline_result_collector;
  import pipeline_pkg::*;

  localparam int unsigned LVL_W = PTR_W + 1;

  logic              clk = 1'b0;
  logic              clear_n = 1'b1;
  logic              load = 1'b0;
  logic              out_ready = 1'b0;
  res_t              res_in = '0;

  res_t              out_data, out_data4;
  logic              out_valid, out_valid4, full, full4, drop_err, drop_err4;
  logic [LVL_W-1:0]  level, level4;
  logic [SUM_W-1:0]  sum;
  logic [3:0]        sum4;
  logic [CNT_W-1:0]  count, count4;

  pipeline_result_collector dut (
    .clk(clk), .clear_n(clear_n), .load(load), .res_in(res_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .sum(sum), .count(count), .drop_err(drop_err)
  );

  pipeline_result_collector #(.SUM_W(4)) dut4 (
    .clk(clk), .clear_n(clear_n), .load(load), .res_in(res_in),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .level(level4), .full(full4), .sum(sum4), .count(count4), .drop_err(drop_err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit ld; int val; bit rdy;
    int lvl; bit vld; int data; int sum; int cnt; bit drop;
  } row_t;

  row_t rows[$];
  int   exp_q[$];
  bit   dl_v [LATENCY];
  int   dl_d [LATENCY];
  int   idle_val = -1;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input bit ld, input int val, input bit rdy,
                              input int lvl, input bit vld, input int data,
                              input int s, input int c, input bit drop);
    row_t r;
    r.rst = rst; r.ld = ld; r.val = val; r.rdy = rdy;
    r.lvl = lvl; r.vld = vld; r.data = data; r.sum = s; r.cnt = c; r.drop = drop;
    rows.push_back(r);
  endfunction

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_drop", int'(drop_err), 0);
    chk("rst_twin", int'({level4, out_valid4, sum4, count4, drop_err4}), 0);
    exp_q.delete();
    for (int i = 0; i < LATENCY; i++) begin dl_v[i] = 1'b0; dl_d[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  // One cycle: drive inputs after the falling edge, score pops, step to next falling edge.
  task automatic tick(input bit ld, input int val, input bit rdy);
    bit cap, pop;
    int due, sz;
    cap = dl_v[LATENCY-1];
    due = dl_d[LATENCY-1];
    load = ld;
    out_ready = rdy;
    if (cap)                res_in = res_t'(due);
    else if (idle_val >= 0) res_in = res_t'(idle_val);
    else                    res_in = res_t'($urandom);
    sz  = exp_q.size();
    pop = (sz != 0) && rdy;
    if (pop) chk("pop_data", int'(out_data), exp_q.pop_front());
    if (cap && (sz < int'(DEPTH) || pop)) exp_q.push_back(due % (1 << DATA_W));
    for (int i = LATENCY - 1; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_d[i] = dl_d[i-1];
    end
    dl_v[0] = ld;
    dl_d[0] = val;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_row(input int idx, input row_t r);
    bit exp_full;
    exp_full = (r.lvl == int'(DEPTH));
    chk($sformatf("row%0d_level", idx), int'(level), r.lvl);
    chk($sformatf("row%0d_valid", idx), int'(out_valid), int'(r.vld));
    chk($sformatf("row%0d_full", idx), int'(full), int'(exp_full));
    if (r.vld) chk($sformatf("row%0d_data", idx), int'(out_data), r.data);
    chk($sformatf("row%0d_sum", idx), int'(sum), r.sum % 256);
    chk($sformatf("row%0d_count", idx), int'(count), r.cnt);
    chk($sformatf("row%0d_drop", idx), int'(drop_err), int'(r.drop));
    chk($sformatf("row%0d_sum4", idx), int'(sum4), r.sum % 16);
    chk($sformatf("row%0d_twin", idx), int'({level4, out_valid4, full4, drop_err4, count4}),
        int'({LVL_W'(r.lvl), r.vld, exp_full, r.drop, CNT_W'(r.cnt)}));
  endtask

  initial begin
    // rst ld val rdy | lvl vld data sum cnt drop
    // basic latency, then a single pop
    add(0,1,1,0, 0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0, 0,0,0);
    add(0,0,0,0, 1,1,1, 1,1,0);
    add(0,0,0,1, 0,0,0, 1,1,0);
    // back-to-back 1,5,0 held, then drained in order
    add(1,0,0,0, 0,0,0, 0,0,0);
    add(0,1,1,0, 0,0,0, 0,0,0);
    add(0,1,5,0, 0,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0, 0,0,0);
    add(0,0,0,0, 1,1,1, 1,1,0);
    add(0,0,0,0, 2,1,1, 6,2,0);
    add(0,0,0,0, 3,1,1, 6,3,0);
    add(0,0,0,1, 2,1,5, 6,3,0);
    add(0,0,0,1, 1,1,0, 6,3,0);
    add(0,0,0,1, 0,0,0, 6,3,0);
    // overflow: six captures of 7 into four slots
    add(1,0,0,0, 0,0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,7,0, 0,0,0, 0,0,0);
    add(0,1,7,0, 1,1,7, 7,1,0);
    add(0,1,7,0, 2,1,7, 14,2,0);
    add(0,1,7,0, 3,1,7, 21,3,0);
    add(0,0,0,0, 4,1,7, 28,4,0);
    add(0,0,0,0, 4,1,7, 28,4,1);
    add(0,0,0,0, 4,1,7, 28,4,1);
    add(0,0,0,1, 3,1,7, 28,4,1);
    add(0,0,0,1, 2,1,7, 28,4,1);
    add(0,0,0,1, 1,1,7, 28,4,1);
    add(0,0,0,1, 0,0,0, 28,4,1);
    // full with simultaneous pop accepts the fifth result
    add(1,0,0,0, 0,0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,7,0, 0,0,0, 0,0,0);
    add(0,1,7,0, 1,1,7, 7,1,0);
    add(0,1,3,0, 2,1,7, 14,2,0);
    add(0,0,0,0, 3,1,7, 21,3,0);
    add(0,0,0,0, 4,1,7, 28,4,0);
    add(0,0,0,1, 4,1,7, 31,5,0);
    add(0,0,0,1, 3,1,7, 31,5,0);
    add(0,0,0,1, 2,1,7, 31,5,0);
    add(0,0,0,1, 1,1,3, 31,5,0);
    add(0,0,0,1, 0,0,0, 31,5,0);
    // accumulator wrap on the 4-bit instance: 7+7+5 = 19 -> 3
    add(1,0,0,0, 0,0,0, 0,0,0);
    add(0,1,7,0, 0,0,0, 0,0,0);
    add(0,1,7,0, 0,0,0, 0,0,0);
    add(0,1,5,0, 0,0,0, 0,0,0);
    add(0,0,0,0, 1,1,7, 7,1,0);
    add(0,0,0,0, 2,1,7, 14,2,0);
    add(0,0,0,0, 3,1,7, 19,3,0);

    @(negedge clk);
    do_reset();
    foreach (rows[i]) begin
      if (rows[i].rst) do_reset();
      else begin
        tick(rows[i].ld, rows[i].val, rows[i].rdy);
        check_row(i, rows[i]);
      end
    end

    // Reset mid-stream: an in-flight load is discarded and later results ignored.
    do_reset();
    tick(1'b1, 2, 1'b0);
    tick(1'b1, 3, 1'b0);
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b0);
    chk("mid_level_before", int'(level), 1);
    chk("mid_sum_before", int'(sum), 2);
    do_reset();
    idle_val = 5;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, 1'b0);
      chk($sformatf("mid_level_after%0d", i), int'(level), 0);
      chk($sformatf("mid_count_after%0d", i), int'(count), 0);
    end
    idle_val = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
